fft8_inplace_sequencer: RTL and testbench
=========================================

# fft8_inplace_sequencer

In-place controller and sample store for the 8-point radix-2 DIT FFT. It accepts 8 complex fp32 samples over a valid/ready stream and stores them in bit-reversed order. It then runs 3 stages × 4 butterflies by driving the combinational butterfly unit and writing its results back into the store. Finally it streams the 8 spectrum bins out in natural order. The block sits directly around the butterfly unit: it feeds the butterfly's operand and twiddle inputs and consumes its outputs.

## Interface
- SIZE_DATA, 32, word width of each re/im component; the twiddle constants are IEEE-754 single precision, so only 32 is supported.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  input ready; high only in LOAD.
- i_data_re, i_data_im  in  SIZE_DATA  input sample.
- o_valid  out  1  output bin valid.
- i_ready  in  1  downstream ready.
- o_data_re, o_data_im  out  SIZE_DATA  output bin X[k].
- o_last  out  1  high with o_valid on bin 7.
- o_busy  out  1  high in COMPUTE and DRAIN.
- o_bf_data_0_re, o_bf_data_0_im, o_bf_data_1_re, o_bf_data_1_im  out  SIZE_DATA  butterfly operands a (top) and b (bottom).
- o_bf_twiddle_re, o_bf_twiddle_im  out  SIZE_DATA  twiddle W8^k.
- i_bf_data_0_re, i_bf_data_0_im, i_bf_data_1_re, i_bf_data_1_im  in  SIZE_DATA  butterfly results: a+bW and a−bW.

## Operation
- **Store.** 8 complex registers mem[0..7]. Counter cnt (3 bits), stage (2 bits), bfly (2 bits).
- **LOAD.**
  - o_ready=1.
  - On i_valid&&o_ready: mem[bitrev3(cnt)] ← input, then cnt++.
  - On the 8th handshake (cnt==7): go to COMPUTE with stage=0, bfly=0.
- **COMPUTE.** One butterfly per cycle, 12 cycles.
  - span = 1<<stage.
  - top = (bfly>>stage)·2·span + (bfly & (span−1)); bot = top+span.
  - k = (bfly & (span−1)) << (2−stage).
  - Operands: o_bf_data_0 = mem[top], o_bf_data_1 = mem[bot], read combinationally.
  - At the edge: mem[top] ← i_bf_data_0 and mem[bot] ← i_bf_data_1.
  - Advance bfly; when bfly wraps from 3, increment stage.
  - After stage 2, bfly 3: go to DRAIN with cnt=0.
- **Twiddle ROM** (re, im):
  - k0 = 0x3F800000, 0x00000000
  - k1 = 0x3F3504F3, 0xBF3504F3
  - k2 = 0x00000000, 0xBF800000
  - k3 = 0xBF3504F3, 0xBF3504F3
- **Butterfly outputs outside COMPUTE.** o_bf_* = 0.
- **DRAIN.**
  - o_valid=1 and o_data=mem[cnt].
  - On i_ready: cnt++.
  - o_last = (cnt==7).
  - Handshake with o_last: return to LOAD with cnt=0.
- **Ignored inputs.** Inputs are ignored outside LOAD. i_ready is ignored outside DRAIN.

## Timing
- **Reset.** Asynchronous and immediate, including mid-LOAD, COMPUTE or DRAIN. It discards any partial frame.
  - State=LOAD and cnt=stage=bfly=0.
  - mem all zero.
  - o_ready=1 (first cycle after deassert), o_valid=0, o_last=0, o_busy=0, o_data=0, o_bf_*=0.
- **Input rate.** Up to 1 sample/cycle.
- **Compute.** Exactly 12 cycles, fixed, with no stall. o_ready=0 and o_valid=0 throughout.
- **Latency.** The 8th input handshake occurs at edge E. o_valid is first high in the cycle after edge E+12.
- **Output rate.** 1 bin/cycle under constant i_ready.
- **Backpressure.** When o_valid && !i_ready: o_data and o_last hold stable and cnt holds.
- **Back-to-back frames.** The cycle after the o_last handshake accepts a new sample. Minimum frame period is 8+12+8 = 28 cycles.
- **Butterfly path.** The butterfly is combinational; mem read → butterfly → mem write is a single-cycle path.

## Test plan
- **Impulse.** x[0]=1.0 (0x3F800000), x[1..7]=0 → all 8 bins re=0x3F800000 and im=±0. o_last only on bin 7. o_valid first rises 12 cycles after the 8th accept.
- **DC.** All x=1.0+0j → X[0]=0x41000000 (8.0). X[1..7] are ±0 re and ±0 im. Sign of zero is not checked.
- **Operand trace.** x[n]=n+0j. Check cycle-level butterfly operands:
  - Stage 0, bfly 0: a=mem[0]=x0=0, b=mem[1]=x4=4.0, twiddle k0.
  - Stage 2, bfly 1: top=1, bot=5, twiddle k1.
  - Final X[0]=28.0 (0x41E00000), X[4]=−4.0+0j.
- **Backpressure.** Random i_valid gaps during load and random i_ready gaps during drain → same spectrum as the DC test. o_data is stable while stalled. No bins are skipped or duplicated.
- **Reset mid-COMPUTE.** Assert i_rst_n=0 at compute cycle 6 → outputs take reset values immediately. After deassert, a fresh impulse frame yields the correct spectrum.
- **Back-to-back frames.** Impulse frame then DC frame with the second frame's samples presented immediately → second frame accepted the cycle after the first frame's o_last handshake. Both spectra are correct.

Source files
------------

// File: rtl/fft8_inplace_sequencer.sv
// In-place sequencer and sample store for an 8-point radix-2 DIT FFT.
// Loads 8 samples in bit-reversed order, runs 12 butterflies through an external
// combinational unit, then drains the bins in natural order.
module fft8_inplace_sequencer #(
    parameter int SIZE_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data_re,
    input  logic [SIZE_DATA-1:0] i_data_im,

    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data_re,
    output logic [SIZE_DATA-1:0] o_data_im,
    output logic                 o_last,
    output logic                 o_busy,

    output logic [SIZE_DATA-1:0] o_bf_data_0_re,
    output logic [SIZE_DATA-1:0] o_bf_data_0_im,
    output logic [SIZE_DATA-1:0] o_bf_data_1_re,
    output logic [SIZE_DATA-1:0] o_bf_data_1_im,
    output logic [SIZE_DATA-1:0] o_bf_twiddle_re,
    output logic [SIZE_DATA-1:0] o_bf_twiddle_im,
    input  logic [SIZE_DATA-1:0] i_bf_data_0_re,
    input  logic [SIZE_DATA-1:0] i_bf_data_0_im,
    input  logic [SIZE_DATA-1:0] i_bf_data_1_re,
    input  logic [SIZE_DATA-1:0] i_bf_data_1_im
);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t               state_q;
    logic [2:0]           cnt_q;
    logic [1:0]           stage_q;
    logic [1:0]           bfly_q;
    logic [SIZE_DATA-1:0] mem_re_q [8];
    logic [SIZE_DATA-1:0] mem_im_q [8];

    logic [2:0] span;
    logic [2:0] span_m1;
    logic [2:0] bfly_w;
    logic [2:0] top_idx;
    logic [2:0] bot_idx;
    logic [1:0] k_idx;
    logic [2:0] load_idx;
    logic [SIZE_DATA-1:0] tw_re;
    logic [SIZE_DATA-1:0] tw_im;

    // Butterfly addressing: groups of 2*span, pairs separated by span.
    always_comb begin
        span    = 3'd1 << stage_q;
        span_m1 = span - 3'd1;
        bfly_w  = {1'b0, bfly_q};
        top_idx = ((bfly_w >> stage_q) << (stage_q + 2'd1)) | (bfly_w & span_m1);
        bot_idx = top_idx + span;
        k_idx   = (bfly_q & span_m1[1:0]) << (2'd2 - stage_q);
    end

    assign load_idx = {cnt_q[0], cnt_q[1], cnt_q[2]};

    always_comb begin
        tw_re = '0;
        tw_im = '0;
        case (k_idx)
            2'd0: begin tw_re = SIZE_DATA'(32'h3F80_0000); tw_im = SIZE_DATA'(32'h0000_0000); end
            2'd1: begin tw_re = SIZE_DATA'(32'h3F35_04F3); tw_im = SIZE_DATA'(32'hBF35_04F3); end
            2'd2: begin tw_re = SIZE_DATA'(32'h0000_0000); tw_im = SIZE_DATA'(32'hBF80_0000); end
            default: begin tw_re = SIZE_DATA'(32'hBF35_04F3); tw_im = SIZE_DATA'(32'hBF35_04F3); end
        endcase
    end

    // Operands are forced to zero outside COMPUTE so the butterfly sees a quiet bus.
    always_comb begin
        o_bf_data_0_re  = '0;
        o_bf_data_0_im  = '0;
        o_bf_data_1_re  = '0;
        o_bf_data_1_im  = '0;
        o_bf_twiddle_re = '0;
        o_bf_twiddle_im = '0;
        if (state_q == ST_COMPUTE) begin
            o_bf_data_0_re  = mem_re_q[top_idx];
            o_bf_data_0_im  = mem_im_q[top_idx];
            o_bf_data_1_re  = mem_re_q[bot_idx];
            o_bf_data_1_im  = mem_im_q[bot_idx];
            o_bf_twiddle_re = tw_re;
            o_bf_twiddle_im = tw_im;
        end
    end

    assign o_ready   = (state_q == ST_LOAD);
    assign o_valid   = (state_q == ST_DRAIN);
    assign o_busy    = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
    assign o_last    = (state_q == ST_DRAIN) && (cnt_q == 3'd7);
    assign o_data_re = (state_q == ST_DRAIN) ? mem_re_q[cnt_q] : '0;
    assign o_data_im = (state_q == ST_DRAIN) ? mem_im_q[cnt_q] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
            // NOTE: the store is reset too, so an aborted frame can never leak into the next spectrum.
            for (int i = 0; i < 8; i++) begin
                mem_re_q[i] <= '0;
                mem_im_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (i_valid) begin
                        mem_re_q[load_idx] <= i_data_re;
                        mem_im_q[load_idx] <= i_data_im;
                        cnt_q              <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q <= ST_COMPUTE;
                            stage_q <= '0;
                            bfly_q  <= '0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    mem_re_q[top_idx] <= i_bf_data_0_re;
                    mem_im_q[top_idx] <= i_bf_data_0_im;
                    mem_re_q[bot_idx] <= i_bf_data_1_re;
                    mem_im_q[bot_idx] <= i_bf_data_1_im;
                    bfly_q            <= bfly_q + 2'd1;
                    if (bfly_q == 2'd3) begin
                        if (stage_q == 2'd2) begin
                            state_q <= ST_DRAIN;
                            stage_q <= '0;
                            cnt_q   <= '0;
                        end else begin
                            stage_q <= stage_q + 2'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_ready) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_inplace_sequencer.sv
// Self-checking bench for fft8_inplace_sequencer with a behavioural fp32 butterfly
// and a scoreboard of hand-computed spectrum bins.
module tb_fft8_inplace_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data_re = '0;
    logic [31:0] i_data_im = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_data_re, o_data_im;
    logic        o_last, o_busy;
    logic [31:0] bf0_re, bf0_im, bf1_re, bf1_im, tw_re, tw_im;
    logic [31:0] r0_re, r0_im, r1_re, r1_im;

    always #5 clk = ~clk;

    fft8_inplace_sequencer #(.SIZE_DATA(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_data_re(i_data_re), .i_data_im(i_data_im),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_data_re(o_data_re), .o_data_im(o_data_im),
        .o_last(o_last), .o_busy(o_busy),
        .o_bf_data_0_re(bf0_re), .o_bf_data_0_im(bf0_im),
        .o_bf_data_1_re(bf1_re), .o_bf_data_1_im(bf1_im),
        .o_bf_twiddle_re(tw_re), .o_bf_twiddle_im(tw_im),
        .i_bf_data_0_re(r0_re), .i_bf_data_0_im(r0_im),
        .i_bf_data_1_re(r1_re), .i_bf_data_1_im(r1_im)
    );

    // fp32 <-> real conversion; denormals flush to zero, which never matters here.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          ee;
        logic [31:0] res;
        d  = $realtobits(r);
        ee = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || ee <= 0) return {d[63], 31'd0};
        if (ee >= 255) return {d[63], 8'hFF, 23'd0};
        res = {d[63], ee[7:0], d[51:29]};
        return res + 32'(d[28]);
    endfunction

    real ar, ai, br, bi, wr, wi, tr, ti;
    always_comb begin
        ar = f2r(bf0_re); ai = f2r(bf0_im);
        br = f2r(bf1_re); bi = f2r(bf1_im);
        wr = f2r(tw_re);  wi = f2r(tw_im);
        tr = br * wr - bi * wi;
        ti = br * wi + bi * wr;
        r0_re = r2f(ar + tr); r0_im = r2f(ai + ti);
        r1_re = r2f(ar - tr); r1_im = r2f(ai - ti);
    end

    typedef struct {
        logic [31:0] re, im, re_m, im_m;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] f_re [8];
    logic [31:0] f_im [8];
    bit          rdy_mode = 1'b0;
    bit          trace_en = 1'b0;
    bit          b2b_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input logic [31:0] mask = 32'hFFFF_FFFF);
        n_checks++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (mask %h) at cycle %0d", name, act, exp, mask, cyc);
        end
    endtask

    task automatic push_bin(input logic [31:0] re, input logic [31:0] im,
                            input logic [31:0] re_m, input logic [31:0] im_m, input logic last);
        exp_t e;
        e.re = re; e.im = im; e.re_m = re_m; e.im_m = im_m; e.last = last;
        sb.push_back(e);
    endtask

    // kind 0 = impulse, 1 = DC, 2 = ramp x[n]=n (only X[0], X[4] known exactly)
    task automatic push_expected(input int kind);
        for (int k = 0; k < 8; k++) begin
            case (kind)
                0: push_bin(32'h3F80_0000, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, k == 7);
                1: push_bin(k == 0 ? 32'h4100_0000 : 32'h0, 32'h0,
                            k == 0 ? 32'hFFFF_FFFF : 32'h7FFF_FFFF, 32'h7FFF_FFFF, k == 7);
                default: begin
                    if (k == 0)      push_bin(32'h41E0_0000, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
                    else if (k == 4) push_bin(32'hC080_0000, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
                    else             push_bin(32'h0, 32'h0, 32'h0, 32'h0, k == 7);
                end
            endcase
        end
    endtask

    task automatic load_frame(input int kind);
        for (int n = 0; n < 8; n++) begin
            f_im[n] = 32'h0;
            case (kind)
                0: f_re[n] = (n == 0) ? 32'h3F80_0000 : 32'h0;
                1: f_re[n] = 32'h3F80_0000;
                default: f_re[n] = r2f(real'(n));
            endcase
        end
    endtask

    task automatic send_frame(input bit gaps);
        bit hs;
        int budget;
        for (int n = 0; n < 8; n++) begin
            if (gaps) begin
                i_valid = 1'b0;
                repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
            end
            i_valid   = 1'b1;
            i_data_re = f_re[n];
            i_data_im = f_im[n];
            hs = 1'b0;
            budget = 0;
            while (!hs && budget < 200) begin
                @(negedge clk);
                hs = o_ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!hs) check("send_timeout", 32'(budget), 32'd0);
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || o_busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            i_ready = rdy_mode ? ($urandom_range(2, 0) != 0) : 1'b1;
        end
    end

    // Monitor: scoreboard pop, hold-stability, latency, handshake timing and operand trace.
    initial begin
        int          acc_in_frame = 0;
        int          e_edge = 0;
        int          last_hs_edge = -100;
        int          out_idx = 0;
        int          cidx = 0;
        bit          lat_pending = 1'b0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_re = '0, prev_im = '0;
        logic        prev_last = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_in_frame = 0; out_idx = 0; cidx = 0;
                lat_pending = 1'b0; prev_stall = 1'b0;
                continue;
            end
            if (i_valid && o_ready) begin
                if (acc_in_frame == 0 && b2b_chk) begin
                    check("b2b_accept_edge", 32'(cyc + 1), 32'(last_hs_edge + 1));
                    b2b_chk = 1'b0;
                end
                acc_in_frame++;
                if (acc_in_frame == 8) begin
                    acc_in_frame = 0;
                    e_edge = cyc + 1;
                    lat_pending = 1'b1;
                end
            end
            if (o_busy && !o_valid) begin
                check("compute_ready_low", 32'(o_ready), 32'd0);
                if (trace_en && cidx == 0) begin
                    check("trace_s0b0_a_re", bf0_re, 32'h0);
                    check("trace_s0b0_b_re", bf1_re, 32'h4080_0000);
                    check("trace_s0b0_tw_re", tw_re, 32'h3F80_0000);
                    check("trace_s0b0_tw_im", tw_im, 32'h0);
                end
                if (trace_en && cidx == 9) begin
                    check("trace_s2b1_a_re", bf0_re, 32'hC080_0000);
                    check("trace_s2b1_a_im", bf0_im, 32'h4080_0000);
                    check("trace_s2b1_b_re", bf1_re, 32'hC080_0000);
                    check("trace_s2b1_b_im", bf1_im, 32'h4080_0000);
                    check("trace_s2b1_tw_re", tw_re, 32'h3F35_04F3);
                    check("trace_s2b1_tw_im", tw_im, 32'hBF35_04F3);
                    trace_en = 1'b0;
                end
                cidx++;
            end else begin
                cidx = 0;
            end
            if (o_valid && lat_pending) begin
                check("first_valid_edge", 32'(cyc), 32'(e_edge + 12));
                lat_pending = 1'b0;
            end
            if (o_valid && prev_stall) begin
                check("hold_re", o_data_re, prev_re);
                check("hold_im", o_data_im, prev_im);
                check("hold_last", 32'(o_last), 32'(prev_last));
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_bin", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    if (e.re_m != 0) check($sformatf("bin%0d_re", out_idx), o_data_re, e.re, e.re_m);
                    if (e.im_m != 0) check($sformatf("bin%0d_im", out_idx), o_data_im, e.im, e.im_m);
                    check($sformatf("bin%0d_last", out_idx), 32'(o_last), 32'(e.last));
                end
                out_idx = (out_idx + 1) % 8;
                if (o_last) last_hs_edge = cyc + 1;
            end
            prev_stall = o_valid && !i_ready;
            prev_re    = o_data_re;
            prev_im    = o_data_im;
            prev_last  = o_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_last"},  32'(o_last),  32'd0);
        check({tag, "_busy"},  32'(o_busy),  32'd0);
        check({tag, "_data_re"}, o_data_re, 32'h0);
        check({tag, "_data_im"}, o_data_im, 32'h0);
        check({tag, "_bf0_re"}, bf0_re, 32'h0);
        check({tag, "_bf1_re"}, bf1_re, 32'h0);
        check({tag, "_tw_re"},  tw_re,  32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check_reset_outputs("rst");

        // Impulse
        @(posedge clk); #1;
        load_frame(0); push_expected(0); send_frame(1'b0); wait_idle();

        // DC
        @(posedge clk); #1;
        load_frame(1); push_expected(1); send_frame(1'b0); wait_idle();

        // Ramp with operand trace
        @(posedge clk); #1;
        trace_en = 1'b1;
        load_frame(2); push_expected(2); send_frame(1'b0); wait_idle();
        check("trace_done", 32'(trace_en), 32'd0);

        // Backpressure on both sides, DC spectrum
        rdy_mode = 1'b1;
        @(posedge clk); #1;
        load_frame(1); push_expected(1); send_frame(1'b1); wait_idle();
        rdy_mode = 1'b0;

        // Reset in compute cycle 6, then a fresh impulse frame
        @(posedge clk); #1;
        load_frame(0); send_frame(1'b0);
        repeat (6) begin @(posedge clk); #1; end
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        check("pre_rst_valid", 32'(o_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        load_frame(0); push_expected(0); send_frame(1'b0); wait_idle();

        // Back-to-back: impulse then DC presented immediately
        @(posedge clk); #1;
        load_frame(0); push_expected(0); push_expected(1); send_frame(1'b0);
        b2b_chk = 1'b1;
        load_frame(1); send_frame(1'b0); wait_idle();
        check("b2b_checked", 32'(b2b_chk), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
